// File: rtl/core_pkg.sv
// Shared definitions for the instruction-fetch arbiter slice: defaults, FSM encoding, index width helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package core_pkg;

   localparam int NUM_CORES_DEF = 8;
   localparam int ADDR_W_DEF    = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_RESP  = 2'd2
   } fetch_state_t;

   // Width of a core index; never below one bit so single-core builds still elaborate.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/imem_fetch_arbiter_if.sv
// Bundle of core request lines, shared memory port and broadcast response of the fetch arbiter.
// Latency: n/a (wiring only).
// Backpressure: none; Req is a level held by each core until its Valid pulse.
interface imem_fetch_arbiter_if
   import core_pkg::*;
#(
   parameter int NUM_CORES = NUM_CORES_DEF,
   parameter int ADDR_W    = ADDR_W_DEF
);

   logic [NUM_CORES-1:0]        Req;
   logic [NUM_CORES*ADDR_W-1:0] ReqAddr;
   logic [ADDR_W-1:0]           MemAddress;
   logic [31:0]                 MemInstruction;
   logic [31:0]                 Instruction;
   logic [NUM_CORES-1:0]        Valid;
   logic                        AlignErr;
   logic                        Busy;

   // Cores and the memory model sit on the master side.
   modport master (
      output Req, ReqAddr, MemInstruction,
      input  MemAddress, Instruction, Valid, AlignErr, Busy
   );

   // The arbiter sits on the slave side.
   modport slave (
      input  Req, ReqAddr, MemInstruction,
      output MemAddress, Instruction, Valid, AlignErr, Busy
   );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: lowest requesting index at or above ptr, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; any=0 when no request is present.
module rr_arbiter
   import core_pkg::*;
#(
   parameter int  NUM_CORES = NUM_CORES_DEF,
   localparam int IDX_W     = idx_width(NUM_CORES)
)
(
   input  logic [NUM_CORES-1:0] req,
   input  logic [IDX_W-1:0]     ptr,
   output logic [NUM_CORES-1:0] gnt,
   output logic [IDX_W-1:0]     idx,
   output logic                 any
);

   localparam logic [IDX_W:0] NC = (IDX_W+1)'(NUM_CORES);

   logic [IDX_W:0] cand;

   // Scan candidates ptr, ptr+1, ... modulo NUM_CORES and keep the first requester.
   always_comb begin
      gnt  = '0;
      idx  = '0;
      any  = 1'b0;
      cand = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         cand = {1'b0, ptr} + (IDX_W+1)'(i);
         if (cand >= NC) cand = cand - NC;
         if (!any && req[cand[IDX_W-1:0]]) begin
            any                  = 1'b1;
            idx                  = cand[IDX_W-1:0];
            gnt[cand[IDX_W-1:0]] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Shares one combinational instruction memory among NUM_CORES cores, round-robin, one fetch at a time.
// Latency: 3 cycles from Req (arbiter idle) to the Valid pulse: arbitrate, fetch, respond.
// Backpressure: losers keep Req high and are re-arbitrated at the next IDLE; no queueing inside.
module imem_fetch_arbiter
   import core_pkg::*;
#(
   parameter int NUM_CORES = NUM_CORES_DEF,
   parameter int ADDR_W    = ADDR_W_DEF
)
(
   input logic                 Clk,
   input logic                 Rst_n,
   imem_fetch_arbiter_if.slave bus
);

   localparam int               IDX_W = idx_width(NUM_CORES);
   localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_CORES - 1);

   fetch_state_t         state_q, state_d;
   logic [IDX_W-1:0]     ptr_q, win_q, arb_idx;
   logic [NUM_CORES-1:0] win_oh_q, arb_gnt, valid_c;
   logic [ADDR_W-1:0]    addr_q, sel_addr;
   logic [31:0]          instr_q;
   logic                 arb_any, align_c, busy_c;

   rr_arbiter #(.NUM_CORES(NUM_CORES)) u_rr (
      .req (bus.Req),
      .ptr (ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   // Route the granted core's address slice out of the flattened address bus.
   always_comb begin
      sel_addr = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (arb_gnt[i]) sel_addr = bus.ReqAddr[i*ADDR_W +: ADDR_W];
      end
   end

   // FSM state register; reset aborts any transaction in flight.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next state and state-decoded outputs; Valid/AlignErr exist only in RESP.
   always_comb begin
      state_d = state_q;
      valid_c = '0;
      align_c = 1'b0;
      busy_c  = 1'b1;
      unique case (state_q)
         ST_IDLE: begin
            busy_c = 1'b0;
            if (arb_any) state_d = ST_FETCH;
         end
         ST_FETCH: state_d = ST_RESP;
         ST_RESP: begin
            valid_c = win_oh_q;
            align_c = (addr_q[1:0] != 2'b00);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Winner/address latch at grant, instruction capture in FETCH, pointer advance leaving RESP.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         ptr_q    <= '0;
         win_q    <= '0;
         win_oh_q <= '0;
         addr_q   <= '0;
         instr_q  <= 32'h0;
      end else begin
         if (state_q == ST_IDLE && arb_any) begin
            win_q    <= arb_idx;
            win_oh_q <= arb_gnt;
            addr_q   <= sel_addr;
         end
         if (state_q == ST_FETCH) instr_q <= bus.MemInstruction;
         if (state_q == ST_RESP)  ptr_q   <= (win_q == LAST) ? '0 : win_q + IDX_W'(1);
      end
   end

   // The latched address doubles as the memory address, so it holds while idle.
   assign bus.MemAddress  = addr_q;
   assign bus.Instruction = instr_q;
   assign bus.Valid       = valid_c;
   assign bus.AlignErr    = align_c;
   assign bus.Busy        = busy_c;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed bench for imem_fetch_arbiter with a queue scoreboard and a negedge response monitor.
// Latency: expected Valid cycle is recorded per transaction and checked by the monitor.
// Backpressure: cores hold Req until their Valid pulse unless a test drops it on purpose.
module tb_imem_fetch_arbiter;

   localparam int N  = 8;
   localparam int AW = 32;

   typedef struct {
      logic [N-1:0] valid;
      logic [31:0]  instr;
      logic         align;
      int           cyc;
   } exp_t;

   logic Clk = 1'b0;
   logic Rst_n;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb[$];
   exp_t mon_e;

   imem_fetch_arbiter_if #(.NUM_CORES(N), .ADDR_W(AW)) bus ();

   imem_fetch_arbiter #(.NUM_CORES(N), .ADDR_W(AW)) dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   // Memory model: word k lives at byte address 4k and reads as C0DE_0000 + k.
   always_comb bus.MemInstruction = 32'hC0DE_0000 | {18'h0, bus.MemAddress[15:2]};

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   task automatic push_exp(input int core, input logic [31:0] word, input logic al, input int at_cyc);
      exp_t e;
      e.valid       = '0;
      e.valid[core] = 1'b1;
      e.instr       = word;
      e.align       = al;
      e.cyc         = at_cyc;
      sb.push_back(e);
   endtask

   task automatic set_addr(input int core, input logic [AW-1:0] a);
      bus.ReqAddr[core*AW +: AW] = a;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   // Returns just after the edge that starts the Valid[core] cycle; bounded.
   task automatic wait_valid(input int core);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(posedge Clk);
         #1;
         if (bus.Valid[core]) seen = 1'b1;
      end
      check($sformatf("valid%0d_seen", core), 64'(seen), 64'd1);
   endtask

   // Monitor: every Valid pulse must match the oldest expected transaction.
   always @(negedge Clk) begin
      if (bus.Valid != '0) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_valid: got %b, expected no pulse", bus.Valid);
         end else begin
            mon_e = sb.pop_front();
            check("valid",    64'(bus.Valid),       64'(mon_e.valid));
            check("instr",    64'(bus.Instruction), 64'(mon_e.instr));
            check("alignerr", 64'(bus.AlignErr),    64'(mon_e.align));
            check("latency",  64'(cyc),             64'(mon_e.cyc));
         end
      end
   end

   initial begin
      Rst_n       = 1'b0;
      bus.Req     = '0;
      bus.ReqAddr = '0;
      #2;
      check("rst_valid",    64'(bus.Valid),       64'd0);
      check("rst_alignerr", 64'(bus.AlignErr),    64'd0);
      check("rst_busy",     64'(bus.Busy),        64'd0);
      check("rst_instr",    64'(bus.Instruction), 64'd0);
      check("rst_memaddr",  64'(bus.MemAddress),  64'd0);
      wait_cycles(2);
      Rst_n = 1'b1;
      wait_cycles(1);

      // Single request from core 2, word 4.
      set_addr(2, 32'h0000_0010);
      bus.Req = 8'b0000_0100;
      push_exp(2, 32'hC0DE_0004, 1'b0, cyc + 2);
      wait_cycles(1);
      check("fetch_memaddr", 64'(bus.MemAddress), 64'h10);
      check("fetch_busy",    64'(bus.Busy),       64'd1);
      wait_valid(2);
      bus.Req[2] = 1'b0;
      wait_cycles(1);
      check("instr_hold", 64'(bus.Instruction), 64'hC0DE_0004);
      check("idle_busy",  64'(bus.Busy),        64'd0);

      // Misaligned address from core 3 reads word 1 with AlignErr.
      set_addr(3, 32'h0000_0006);
      bus.Req = 8'b0000_1000;
      push_exp(3, 32'hC0DE_0001, 1'b1, cyc + 2);
      wait_valid(3);
      bus.Req = '0;
      wait_cycles(1);

      // Core 5 drops Req during FETCH; the transaction still completes.
      set_addr(5, 32'h0000_0020);
      bus.Req[5] = 1'b1;
      push_exp(5, 32'hC0DE_0008, 1'b0, cyc + 2);
      wait_cycles(1);
      bus.Req[5] = 1'b0;
      wait_cycles(3);

      // Ptr is now 6: with 5 and 6 requesting, 6 goes first.
      set_addr(6, 32'h0000_0024);
      bus.Req = 8'b0110_0000;
      push_exp(6, 32'hC0DE_0009, 1'b0, cyc + 2);
      push_exp(5, 32'hC0DE_0008, 1'b0, cyc + 5);
      wait_valid(6);
      bus.Req[6] = 1'b0;
      wait_valid(5);
      bus.Req[5] = 1'b0;
      wait_cycles(1);

      // Serve core 6 alone so Ptr becomes 7, then check the wrap 7 -> 0.
      bus.Req = 8'b0100_0000;
      push_exp(6, 32'hC0DE_0009, 1'b0, cyc + 2);
      wait_valid(6);
      bus.Req = '0;
      wait_cycles(1);
      set_addr(7, 32'h0000_0030);
      set_addr(0, 32'h0000_0003);
      bus.Req = 8'b1000_0001;
      push_exp(7, 32'hC0DE_000C, 1'b0, cyc + 2);
      push_exp(0, 32'hC0DE_0000, 1'b1, cyc + 5);
      wait_valid(7);
      bus.Req[7] = 1'b0;
      wait_valid(0);
      bus.Req[0] = 1'b0;
      wait_cycles(1);

      // Reset asserted in FETCH: no Valid, outputs clear without a clock edge.
      set_addr(4, 32'h0000_0044);
      bus.Req = 8'b0001_0000;
      wait_cycles(1);
      check("rst_pre_memaddr", 64'(bus.MemAddress), 64'h44);
      check("rst_pre_busy",    64'(bus.Busy),       64'd1);
      Rst_n = 1'b0;
      #1;
      check("arst_valid",    64'(bus.Valid),       64'd0);
      check("arst_alignerr", 64'(bus.AlignErr),    64'd0);
      check("arst_busy",     64'(bus.Busy),        64'd0);
      check("arst_instr",    64'(bus.Instruction), 64'd0);
      check("arst_memaddr",  64'(bus.MemAddress),  64'd0);
      bus.Req = '0;
      for (int i = 0; i < N; i++) set_addr(i, 32'h0000_0100 + 32'(4 * i));
      wait_cycles(3);

      // All cores from reset: order 0..7 then 0, one every 3 cycles.
      Rst_n   = 1'b1;
      bus.Req = '1;
      for (int j = 0; j < 9; j++)
         push_exp(j % 8, 32'hC0DE_0040 + 32'(j % 8), 1'b0, cyc + 2 + 3 * j);
      for (int j = 0; j < 9; j++) wait_valid(j % 8);
      bus.Req = '0;
      wait_cycles(4);

      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
